pipeline_hazard_ctrl: RTL

//  Central stall/flush controller for the 5-stage RV32 pipeline. Drives the IF_ID, ID_EX,
//  EX_MEM and MEM_WB register enables and NOP injects.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipeline_hazard_ctrl_if.sv | 12 +
 rtl/dmem_handshake_fsm.sv | 95 +++++++++
 rtl/pipeline_hazard_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: memory FSM state
// encoding and architectural constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Data-memory handshake bundle between the hazard controller (master) and
// the data memory (slave).
interface pipeline_hazard_ctrl_if;

    logic        dmem_req;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (output dmem_req, input dmem_ack, input dmem_rdata);
    modport slave  (input dmem_req, output dmem_ack, output dmem_rdata);

endinterface

// File: rtl/dmem_handshake_fsm.sv
// Multi-cycle data-memory access sequencer: IDLE -> (BUSY) -> DONE with an
// abort timeout, load-data capture and a sticky error flag.
module dmem_handshake_fsm
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_i,
    input  logic        ack_i,
    input  logic [31:0] rdata_i,
    output logic        busy_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_err_o
);

    localparam logic [1:0]       ST_IDLE  = IDLE;
    localparam logic [1:0]       ST_BUSY  = BUSY;
    localparam logic [1:0]       ST_DONE  = DONE;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             busy_s;

    // Next-state, timeout and capture logic; ack wins over a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        busy_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_i) begin
                    busy_s = 1'b1;
                    if (ack_i) begin
                        rdata_d = rdata_i;
                        state_d = ST_DONE;
                    end else begin
                        tmo_d   = {TMO_W{1'b0}};
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                busy_s = 1'b1;
                tmo_d  = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
                if (ack_i) begin
                    rdata_d = rdata_i;
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tmo_q   <= {TMO_W{1'b0}};
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Gated by rst_n so a reset mid-access drops the request at once.
    assign busy_o      = busy_s & rst_n;
    assign mem_rdata_o = rdata_q;
    assign mem_err_o   = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32 pipeline: memory-wait freeze,
// load-use bubbles, wrong-path squash and performance counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             ifid_rs1,
    input  logic [4:0]             ifid_rs2,
    input  logic                   ifid_use_rs1,
    input  logic                   ifid_use_rs2,
    input  logic                   idex_mem_read,
    input  logic [4:0]             idex_rd,
    input  logic                   redirect,
    input  logic                   exmem_mem_read,
    input  logic                   exmem_mem_write,
    pipeline_hazard_ctrl_if.master dmem,
    output logic [31:0]            mem_rdata,
    output logic                   mem_stall,
    output logic                   stall,
    output logic                   idex_nop,
    output logic                   ifid_nop,
    output logic                   mem_err,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    logic             op_s;
    logic             busy_s;
    logic             luh_s;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign op_s = exmem_mem_read | exmem_mem_write;

    dmem_handshake_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_i        (op_s),
        .ack_i       (dmem.dmem_ack),
        .rdata_i     (dmem.dmem_rdata),
        .busy_o      (busy_s),
        .mem_rdata_o (mem_rdata),
        .mem_err_o   (mem_err)
    );

    assign dmem.dmem_req = busy_s;
    assign mem_stall     = busy_s;

    // Hazard detection and priority: mem_stall > load-use > redirect.
    always_comb begin
        luh_s = idex_mem_read && (idex_rd != REG_ZERO) &&
                ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                 (ifid_use_rs2 && (ifid_rs2 == idex_rd)));
        if (rst_n && !busy_s) begin
            stall    = luh_s;
            idex_nop = luh_s;
            ifid_nop = redirect && !luh_s;
        end else begin
            stall    = 1'b0;
            idex_nop = 1'b0;
            ifid_nop = 1'b0;
        end
    end

    // Performance counter increments; both wrap naturally at 2^CNT_W.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, (mem_stall | stall)};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, ifid_nop};
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
